// File: rtl/regfile_pkg.sv
// Shared definitions for the register file: index legality and the
// per-port read-source priority used by both read ports.
package regfile_pkg;

    // Widest index / count the helper functions accept (NUM_REGS <= 256).
    localparam int unsigned IDX_ARG_W = 8;
    localparam int unsigned CNT_ARG_W = 9;

    // Source selected for a read port's value.
    typedef enum logic [1:0] {
        RD_SEL_ZERO   = 2'd0,
        RD_SEL_BYPASS = 2'd1,
        RD_SEL_ARRAY  = 2'd2
    } rd_sel_e;

    // An index is usable when it names an existing register and is not the
    // hardwired zero register.
    function automatic logic idx_legal(
        input logic [IDX_ARG_W-1:0] idx,
        input logic [CNT_ARG_W-1:0] num_regs,
        input logic                 zero_reg
    );
        logic in_range;
        logic is_zero;
        in_range = ({1'b0, idx} < num_regs);
        is_zero  = zero_reg && (idx == 8'd0);
        return in_range && !is_zero;
    endfunction

    // Read priority: disabled, then illegal index, then write-first bypass,
    // then the stored value.
    function automatic rd_sel_e rd_select(
        input logic en,
        input logic legal,
        input logic bypass_hit
    );
        rd_sel_e sel;
        if (!en) begin
            sel = RD_SEL_ZERO;
        end else if (!legal) begin
            sel = RD_SEL_ZERO;
        end else if (bypass_hit) begin
            sel = RD_SEL_BYPASS;
        end else begin
            sel = RD_SEL_ARRAY;
        end
        return sel;
    endfunction

endpackage

// File: rtl/reg_file_rdport.sv
// One read port: index check, write-first bypass, optional output register
// with valid strobe, and busy-scoreboard lookup.
module reg_file_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int ZERO_REG = 1,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic              wr_acc,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] regs [NUM_REGS],
    input  logic [NUM_REGS-1:0] busy_vec,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_busy
);

    logic              legal_s;
    logic              hit_s;
    logic [IDX_W-1:0]  safe_idx_s;
    rd_sel_e           sel_s;
    logic [DATA_W-1:0] val_s;

    // Resolve the read value and the hazard flag for this port.
    always_comb begin
        legal_s    = idx_legal(8'(rd_idx), 9'(NUM_REGS), (ZERO_REG != 0));
        hit_s      = wr_acc && (wr_idx == rd_idx);
        // Illegal indices are steered to entry 0 so the lookup never leaves the array.
        if (legal_s) begin
            safe_idx_s = rd_idx;
        end else begin
            safe_idx_s = {IDX_W{1'b0}};
        end
        sel_s = rd_select(rd_en, legal_s, hit_s);
        case (sel_s)
            RD_SEL_BYPASS: val_s = wr_data;
            RD_SEL_ARRAY:  val_s = regs[safe_idx_s];
            default:       val_s = {DATA_W{1'b0}};
        endcase
        rd_busy = rd_en && legal_s && busy_vec[safe_idx_s] && !hit_s;
    end

    generate
        if (READ_LAT != 0) begin : g_reg_read
            logic [DATA_W-1:0] data_d;
            logic [DATA_W-1:0] data_q;
            logic              valid_d;
            logic              valid_q;

            // Next output state: capture the value when enabled, otherwise clear.
            always_comb begin
                if (rd_en) begin
                    data_d  = val_s;
                    valid_d = 1'b1;
                end else begin
                    data_d  = {DATA_W{1'b0}};
                    valid_d = 1'b0;
                end
            end

            // Output register with single-cycle valid pulse.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_q  <= {DATA_W{1'b0}};
                    valid_q <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            assign rd_data  = data_q;
            assign rd_valid = valid_q;
        end else begin : g_comb_read
            assign rd_data  = val_s;
            assign rd_valid = rd_en;
        end
    endgenerate

endmodule

// File: rtl/reg_file_zm.sv
// Two-read / one-write register file with write-first bypass, optional
// registered reads and a per-register busy scoreboard.
module reg_file_zm
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int ZERO_REG = 1,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd1_en,
    input  logic [IDX_W-1:0]  rd1_idx,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd1_valid,
    output logic              rd1_busy,
    input  logic              rd2_en,
    input  logic [IDX_W-1:0]  rd2_idx,
    output logic [DATA_W-1:0] rd2_data,
    output logic              rd2_valid,
    output logic              rd2_busy,
    input  logic              bsy_set,
    input  logic [IDX_W-1:0]  bsy_idx
);

    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] busy_q;
    logic                wr_acc_s;
    logic                bsy_acc_s;

    // Accept writes and busy marks only for real, writable registers.
    always_comb begin
        wr_acc_s  = wr_en && idx_legal(8'(wr_idx), 9'(NUM_REGS), (ZERO_REG != 0));
        bsy_acc_s = bsy_set && idx_legal(8'(bsy_idx), 9'(NUM_REGS), (ZERO_REG != 0));
    end

    // Next storage and scoreboard state; a new producer mark overrides the
    // clear from a same-index write.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_acc_s) begin
            regs_d[wr_idx] = wr_data;
            busy_d[wr_idx] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (bsy_acc_s) begin
            busy_d[bsy_idx] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
    end

    // Register array and busy bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '{default: {DATA_W{1'b0}}};
            busy_q <= {NUM_REGS{1'b0}};
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    reg_file_rdport #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .ZERO_REG (ZERO_REG),
        .READ_LAT (READ_LAT)
    ) u_rd1 (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd1_en),
        .rd_idx   (rd1_idx),
        .wr_acc   (wr_acc_s),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .regs     (regs_q),
        .busy_vec (busy_q),
        .rd_data  (rd1_data),
        .rd_valid (rd1_valid),
        .rd_busy  (rd1_busy)
    );

    reg_file_rdport #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .ZERO_REG (ZERO_REG),
        .READ_LAT (READ_LAT)
    ) u_rd2 (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd2_en),
        .rd_idx   (rd2_idx),
        .wr_acc   (wr_acc_s),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .regs     (regs_q),
        .busy_vec (busy_q),
        .rd_data  (rd2_data),
        .rd_valid (rd2_valid),
        .rd_busy  (rd2_busy)
    );

endmodule

// File: tb/tb_reg_file_zm.sv
// Directed bench for reg_file_zm with 12 registers and registered reads.
module tb_reg_file_zm;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 12;
    localparam int IDX_W    = 4;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              rd1_en;
    logic [IDX_W-1:0]  rd1_idx;
    logic [DATA_W-1:0] rd1_data;
    logic              rd1_valid;
    logic              rd1_busy;
    logic              rd2_en;
    logic [IDX_W-1:0]  rd2_idx;
    logic [DATA_W-1:0] rd2_data;
    logic              rd2_valid;
    logic              rd2_busy;
    logic              bsy_set;
    logic [IDX_W-1:0]  bsy_idx;

    int errors = 0;
    int checks = 0;

    reg_file_zm #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (1),
        .READ_LAT (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .rd1_en    (rd1_en),
        .rd1_idx   (rd1_idx),
        .rd1_data  (rd1_data),
        .rd1_valid (rd1_valid),
        .rd1_busy  (rd1_busy),
        .rd2_en    (rd2_en),
        .rd2_idx   (rd2_idx),
        .rd2_data  (rd2_data),
        .rd2_valid (rd2_valid),
        .rd2_busy  (rd2_busy),
        .bsy_set   (bsy_set),
        .bsy_idx   (bsy_idx)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Directed sequence.
    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_idx = 4'd0; wr_data = 32'd0;
        rd1_en = 1'b0; rd1_idx = 4'd0; rd2_en = 1'b0; rd2_idx = 4'd0;
        bsy_set = 1'b0; bsy_idx = 4'd0;
        tick();
        tick();
        check("reset_rd1_data", rd1_data, 32'd0);
        check("reset_rd1_valid", {31'd0, rd1_valid}, 32'd0);
        check("reset_rd2_data", rd2_data, 32'd0);
        check("reset_rd2_valid", {31'd0, rd2_valid}, 32'd0);
        rst = 1'b1;
        tick();

        // Write R3, read it two cycles later on both ports.
        wr_en = 1'b1; wr_idx = 4'd3; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0;
        tick();
        rd1_en = 1'b1; rd1_idx = 4'd3; rd2_en = 1'b1; rd2_idx = 4'd3;
        tick();
        check("wr_rd_rd1_data", rd1_data, 32'hDEADBEEF);
        check("wr_rd_rd1_valid", {31'd0, rd1_valid}, 32'd1);
        check("wr_rd_rd2_data", rd2_data, 32'hDEADBEEF);
        check("wr_rd_rd2_valid", {31'd0, rd2_valid}, 32'd1);
        rd1_en = 1'b0; rd2_en = 1'b0;
        tick();
        check("disable_rd1_data", rd1_data, 32'd0);
        check("disable_rd1_valid", {31'd0, rd1_valid}, 32'd0);

        // R7=0xAA with a same-cycle busy mark: busy must survive the write.
        wr_en = 1'b1; wr_idx = 4'd7; wr_data = 32'h000000AA;
        bsy_set = 1'b1; bsy_idx = 4'd7;
        tick();
        wr_en = 1'b0; bsy_set = 1'b0;
        rd2_en = 1'b1; rd2_idx = 4'd7;
        #1;
        check("r7_busy_pending", {31'd0, rd2_busy}, 32'd1);
        wr_en = 1'b1; wr_idx = 4'd7; wr_data = 32'h12345678;
        #1;
        check("bypass_rd2_busy", {31'd0, rd2_busy}, 32'd0);
        tick();
        check("bypass_rd2_data", rd2_data, 32'h12345678);
        check("bypass_rd2_valid", {31'd0, rd2_valid}, 32'd1);
        wr_en = 1'b0;
        #1;
        check("r7_busy_cleared", {31'd0, rd2_busy}, 32'd0);
        rd2_en = 1'b0;

        // Zero register ignores writes and busy marks, and blocks bypass.
        wr_en = 1'b1; wr_idx = 4'd0; wr_data = 32'hFFFFFFFF;
        tick();
        wr_en = 1'b0; bsy_set = 1'b1; bsy_idx = 4'd0;
        tick();
        bsy_set = 1'b0;
        wr_en = 1'b1; wr_idx = 4'd0; wr_data = 32'hFFFFFFFF;
        rd1_en = 1'b1; rd1_idx = 4'd0; rd2_en = 1'b1; rd2_idx = 4'd0;
        #1;
        check("r0_rd1_busy", {31'd0, rd1_busy}, 32'd0);
        check("r0_rd2_busy", {31'd0, rd2_busy}, 32'd0);
        tick();
        check("r0_rd1_data", rd1_data, 32'd0);
        check("r0_rd2_data", rd2_data, 32'd0);
        check("r0_rd1_valid", {31'd0, rd1_valid}, 32'd1);
        wr_en = 1'b0; rd1_en = 1'b0; rd2_en = 1'b0;

        // Scoreboard on R4.
        bsy_set = 1'b1; bsy_idx = 4'd4;
        tick();
        bsy_set = 1'b0; rd1_en = 1'b1; rd1_idx = 4'd4;
        #1;
        check("r4_busy_a", {31'd0, rd1_busy}, 32'd1);
        tick();
        check("r4_busy_b", {31'd0, rd1_busy}, 32'd1);
        wr_en = 1'b1; wr_idx = 4'd4; wr_data = 32'h00000044;
        #1;
        check("r4_busy_wr_cycle", {31'd0, rd1_busy}, 32'd0);
        tick();
        check("r4_data_44", rd1_data, 32'h00000044);
        wr_en = 1'b0;
        #1;
        check("r4_busy_after_wr", {31'd0, rd1_busy}, 32'd0);
        bsy_set = 1'b1; bsy_idx = 4'd4;
        wr_en = 1'b1; wr_idx = 4'd4; wr_data = 32'h00000055;
        tick();
        bsy_set = 1'b0; wr_en = 1'b0;
        #1;
        check("r4_new_producer_busy", {31'd0, rd1_busy}, 32'd1);
        check("r4_data_55", rd1_data, 32'h00000055);
        wr_en = 1'b1; wr_idx = 4'd4; wr_data = 32'h00000066;
        tick();
        wr_en = 1'b0; rd1_en = 1'b0;

        // Range boundaries: R11 is the last register, 12 and 13 do not exist.
        wr_en = 1'b1; wr_idx = 4'd11; wr_data = 32'h0000000B;
        tick();
        wr_en = 1'b1; wr_idx = 4'd12; wr_data = 32'h12121212;
        bsy_set = 1'b1; bsy_idx = 4'd13;
        rd1_en = 1'b1; rd1_idx = 4'd11;
        tick();
        check("r11_data", rd1_data, 32'h0000000B);
        bsy_set = 1'b0;
        wr_en = 1'b1; wr_idx = 4'd13; wr_data = 32'h13131313;
        rd1_idx = 4'd12; rd2_en = 1'b1; rd2_idx = 4'd13;
        #1;
        check("idx13_busy", {31'd0, rd2_busy}, 32'd0);
        tick();
        check("idx12_data", rd1_data, 32'd0);
        check("idx13_bypass_data", rd2_data, 32'd0);
        check("idx13_valid", {31'd0, rd2_valid}, 32'd1);
        wr_en = 1'b0; rd1_idx = 4'd13; rd2_idx = 4'd3;
        tick();
        check("idx13_data", rd1_data, 32'd0);
        check("r3_unchanged", rd2_data, 32'hDEADBEEF);
        rd1_idx = 4'd1; rd2_idx = 4'd5;
        tick();
        check("r1_untouched", rd1_data, 32'd0);
        check("r5_untouched", rd2_data, 32'd0);

        // Asynchronous reset in the middle of activity.
        rd1_idx = 4'd3; rd2_idx = 4'd11;
        wr_en = 1'b1; wr_idx = 4'd5; wr_data = 32'h000055AA;
        bsy_set = 1'b1; bsy_idx = 4'd9;
        tick();
        check("pre_reset_rd1", rd1_data, 32'hDEADBEEF);
        check("pre_reset_rd2", rd2_data, 32'h0000000B);
        bsy_set = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_rd1_data", rd1_data, 32'd0);
        check("async_rd1_valid", {31'd0, rd1_valid}, 32'd0);
        check("async_rd2_data", rd2_data, 32'd0);
        check("async_rd2_valid", {31'd0, rd2_valid}, 32'd0);
        wr_en = 1'b1; wr_idx = 4'd5; wr_data = 32'h00000077;
        tick();
        rst = 1'b1; wr_en = 1'b0;
        rd1_idx = 4'd5; rd2_idx = 4'd3;
        tick();
        check("post_reset_r5", rd1_data, 32'd0);
        check("post_reset_r3", rd2_data, 32'd0);
        check("post_reset_valid", {31'd0, rd1_valid}, 32'd1);
        rd1_idx = 4'd9;
        #1;
        check("post_reset_busy9", {31'd0, rd1_busy}, 32'd0);
        rd1_en = 1'b0; rd2_en = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_zm.md
Name: reg_file_zm

Overview:
- Parametrised multi-register file with two read ports and one write port.
- Replaces per-slot single-register cells that each compare a register number themselves.
- Adds four things the slot cells lack: configurable width and depth, write-first bypass, optional registered read with valid strobe, and a per-register busy scoreboard for producer/consumer hazard stalls.
- Sits between decode (read indices) and writeback (write index/data) in the CPU datapath.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 16, number of architectural registers (2..256, need not be a power of two).
- IDX_W, $clog2(NUM_REGS), index width (derived, not overridden).
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and busy marks.
- READ_LAT, 1, 0 = combinational read, 1 = registered read.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_idx  in  IDX_W  write register index.
- wr_data  in  DATA_W  write data.
- rd1_en  in  1  port 1 read enable.
- rd1_idx  in  IDX_W  port 1 register index.
- rd1_data  out  DATA_W  port 1 read data.
- rd1_valid  out  1  port 1 data valid.
- rd1_busy  out  1  port 1 source register pending (combinational).
- rd2_en, rd2_idx, rd2_data, rd2_valid, rd2_busy: same as port 1, for port 2.
- bsy_set  in  1  mark a register as having an outstanding producer.
- bsy_idx  in  IDX_W  register index to mark.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers and all busy bits go to 0.
  - rd*_data=0 and rd*_valid=0.
  - Takes effect immediately and mid-operation; a write in the reset cycle is lost.
- Write: at a rising edge with wr_en=1, reg[wr_idx] <= wr_data, except in two cases, where the write is ignored:
  - wr_idx >= NUM_REGS;
  - wr_idx==0 with ZERO_REG=1.
- Read value, per port, computed in this priority order:
  1. Port disabled -> 0. A disabled port drives 0, never Z.
  2. Index out of range, or index 0 with ZERO_REG=1 -> 0.
  3. wr_en=1 and wr_idx==rd_idx (write actually accepted) -> wr_data (write-first bypass).
  4. Otherwise reg[rd_idx].
- READ_LAT=0:
  - rd*_data is the read value combinationally.
  - rd*_valid = rd*_en.
- READ_LAT=1:
  - rd*_data is the read value sampled at the edge where rd*_en=1; it appears the next cycle.
  - rd*_valid is a 1-cycle pulse in that same cycle.
  - When rd*_en=0 at an edge: rd*_data <= 0 and rd*_valid <= 0.
  - Bypass is evaluated in the sampling cycle, so a write in cycle N is seen by a read enabled in cycle N.
- Both ports may read the same index in the same cycle and return identical data.
- Busy scoreboard (one bit per register):
  - bsy_set=1 sets busy[bsy_idx] at the edge.
  - An accepted write clears busy[wr_idx] at the edge.
  - bsy_set and a write to the same index in the same cycle -> busy ends 1 (new producer wins).
  - A write to a different index clears only that index's bit.
  - bsy_set to index 0 (ZERO_REG=1) or to an out-of-range index is ignored.
- rd*_busy:
  - = rd*_en & busy[rd*_idx] & ~(wr_en & wr_idx==rd*_idx & write accepted).
  - A same-cycle write resolves the hazard through the bypass.
  - Out-of-range index -> 0.
- No other state. Throughput is one write and two reads every cycle with no stall.

Decomposition:
- Shared package regfile_pkg holds:
  - the index-legality function (range check plus zero-register check);
  - the read-mux priority function, used by both ports.
- One natural sub-module, reg_file_rdport: index check, bypass mux, optional output register and valid, busy lookup. It is instantiated twice.
- Storage array and scoreboard stay in the top module.

Test Plan:
- Reset: rst low mid-stream -> all rd*_data=0 and valid=0 at once; after release, reading R5 returns 0.
- Write then read (READ_LAT=1): write R3=0xDEADBEEF in cycle 0, rd1_en R3 in cycle 2 -> rd1_data=0xDEADBEEF and rd1_valid=1 in cycle 3; R3 on port 2 is identical.
- Bypass: same cycle wr_en R7=0x12345678 and rd2_en R7 (old value 0xAA) -> port 2 returns 0x12345678 (next cycle if READ_LAT=1, same cycle if 0); rd2_busy=0.
- Zero register: write R0=0xFFFFFFFF, then bsy_set R0, then read R0 on both ports -> data 0, busy 0.
- Scoreboard: bsy_set R4, read R4 -> rd1_busy=1 until the cycle wr_en R4 occurs; same-cycle bsy_set R4 with a write to R4 -> busy still 1 the next cycle.
- Range and disable: NUM_REGS=12, write idx 13 -> no register changes and a read of idx 13 returns 0; rd1_en=0 -> rd1_data=0 and rd1_valid=0.
